// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and the instruction memory (slave).
interface instruction_fetch_unit_if #(
    parameter int ADDRESSWIDTH      = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic [ADDRESSWIDTH-1:0]      imem_address;
    logic [INSTRUCTION_WIDTH-1:0] imem_instruction;

    modport master (output imem_address, input imem_instruction);
    modport slave  (input imem_address, output imem_instruction);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage of the MIPS-lite pipeline: PC, IF/ID register, redirect/flush/stall, HALT and fault handling.
// Optional perf counters are enabled with `define FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
    parameter int                    ADDRESSWIDTH        = 32,
    parameter int                    INSTRUCTION_WIDTH   = 32,
    parameter int                    BYTESPERINSTRUCTION = 4,
    parameter logic [ADDRESSWIDTH-1:0] RESET_PC          = '0,
    parameter logic [5:0]            HALT_OPCODE         = 6'h11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         redirect_valid,
    input  logic [ADDRESSWIDTH-1:0]      redirect_pc,
    instruction_fetch_unit_if.master     imem,
    output logic [INSTRUCTION_WIDTH-1:0] if_id_instruction,
    output logic [ADDRESSWIDTH-1:0]      if_id_pc4,
    output logic                         if_id_valid,
    output logic                         halted,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0]                  perf_fetch_count,
    output logic [31:0]                  perf_stall_count,
`endif
    output logic                         fetch_fault
);

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    localparam logic [ADDRESSWIDTH-1:0] PC_INC     = ADDRESSWIDTH'(BYTESPERINSTRUCTION);
    localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK = ADDRESSWIDTH'(BYTESPERINSTRUCTION - 1);

    state_t                         state, state_n;
    logic [ADDRESSWIDTH-1:0]        pc, pc_n, pc_plus;
    logic [INSTRUCTION_WIDTH-1:0]   instr_n;
    logic [ADDRESSWIDTH-1:0]        pc4_n;
    logic                           valid_n;
    logic                           capture;
    logic                           misaligned;
    logic                           is_halt;

    assign pc_plus           = pc + PC_INC;
    assign misaligned        = |(redirect_pc & ALIGN_MASK);
    assign is_halt           = (imem.imem_instruction[31:26] == HALT_OPCODE);
    assign imem.imem_address = pc;
    assign halted            = (state == HALTED);
    assign fetch_fault       = (state == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= RUN;
            pc                <= RESET_PC;
            if_id_instruction <= '0;
            if_id_pc4         <= '0;
            if_id_valid       <= 1'b0;
        end else begin
            state             <= state_n;
            pc                <= pc_n;
            if_id_instruction <= instr_n;
            if_id_pc4         <= pc4_n;
            if_id_valid       <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = if_id_instruction;
        pc4_n   = if_id_pc4;
        valid_n = if_id_valid;
        capture = 1'b0;
        case (state)
            RUN, HALTED: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    instr_n = '0;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                    state_n = misaligned ? FAULT : RUN;
                end else if (flush) begin
                    instr_n = '0;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                    if (!stall && state == RUN) pc_n = pc_plus;
                end else if (stall) begin
                    // hold PC and IF/ID; in HALTED this keeps the HALT in IF/ID
                end else if (state == RUN) begin
                    capture = 1'b1;
                    pc_n    = pc_plus;
                    instr_n = imem.imem_instruction;
                    pc4_n   = pc_plus;
                    valid_n = 1'b1;
                    if (is_halt) state_n = HALTED;
                end else begin
                    // HALT already sent down once; feed bubbles while stopped
                    instr_n = '0;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (capture && perf_fetch_count != '1)
                perf_fetch_count <= perf_fetch_count + 32'd1;
            if (state == RUN && stall && !redirect_valid && perf_stall_count != '1)
                perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`endif

endmodule
